ysyx_22040931_mdu: RTL and testbench

Iterative multiply/divide unit for the RV64M group, sitting in the execute stage directly downstream of the R-type decoder. It consumes the decoder's `aluop`/`exop` control together with both register operands. It computes the product, quotient or remainder over multiple cycles and returns one 64-bit result through a valid/ready handshake. The pipeline stalls on `busy`.

---
 rtl/ysyx_22040931_mdu_pkg.sv | 101 ++++++++++
 rtl/ysyx_22040931_divcore.sv | 60 ++++++
 rtl/ysyx_22040931_mdu.sv | 231 +++++++++++++++++++++++
 tb/tb_ysyx_22040931_mdu.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040931_mdu_pkg.sv
// Shared definitions for the RV64M multiply/divide unit: operation codes,
// execute-class codes, FSM state encoding and small operand helpers.
package ysyx_22040931_mdu_pkg;

    // ALU operation codes (non-M codes such as ADD share this space)
    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_MUL    = 5'd16;
    localparam logic [4:0] ALU_MULH   = 5'd17;
    localparam logic [4:0] ALU_MULHSU = 5'd18;
    localparam logic [4:0] ALU_MULHU  = 5'd19;
    localparam logic [4:0] ALU_DIV    = 5'd20;
    localparam logic [4:0] ALU_DIVU   = 5'd21;
    localparam logic [4:0] ALU_REM    = 5'd22;
    localparam logic [4:0] ALU_REMU   = 5'd23;
    localparam logic [4:0] ALU_DIVW   = 5'd24;
    localparam logic [4:0] ALU_DIVUW  = 5'd25;
    localparam logic [4:0] ALU_REMW   = 5'd26;
    localparam logic [4:0] ALU_REMUW  = 5'd27;

    // Execute class codes
    localparam logic [2:0] EXOP_ARITH = 3'd0;
    localparam logic [2:0] EXOP_SHORT = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    function automatic logic is_mul_op(input logic [4:0] op);
        case (op)
            ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU: is_mul_op = 1'b1;
            default:                                 is_mul_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_div_op(input logic [4:0] op);
        case (op)
            ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
            ALU_DIVW, ALU_DIVUW, ALU_REMW, ALU_REMUW: is_div_op = 1'b1;
            default:                                 is_div_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_rem_op(input logic [4:0] op);
        case (op)
            ALU_REM, ALU_REMU, ALU_REMW, ALU_REMUW: is_rem_op = 1'b1;
            default:                               is_rem_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_word_op(input logic [4:0] op);
        case (op)
            ALU_DIVW, ALU_DIVUW, ALU_REMW, ALU_REMUW: is_word_op = 1'b1;
            default:                                 is_word_op = 1'b0;
        endcase
    endfunction

    function automatic logic src1_signed(input logic [4:0] op);
        case (op)
            ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM,
            ALU_DIVW, ALU_REMW: src1_signed = 1'b1;
            default:            src1_signed = 1'b0;
        endcase
    endfunction

    function automatic logic src2_signed(input logic [4:0] op);
        case (op)
            ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM,
            ALU_DIVW, ALU_REMW: src2_signed = 1'b1;
            default:            src2_signed = 1'b0;
        endcase
    endfunction

    // Word mode takes the low 32 bits, sign- or zero-extended
    function automatic logic [63:0] ext_operand(input logic [63:0] v, input logic word,
                                                input logic sgn);
        if (!word) begin
            ext_operand = v;
        end else if (sgn) begin
            ext_operand = {{32{v[31]}}, v[31:0]};
        end else begin
            ext_operand = {32'd0, v[31:0]};
        end
    endfunction

    // Word results are the low 32 bits sign-extended
    function automatic logic [63:0] word_fix(input logic [63:0] v, input logic word);
        word_fix = word ? {{32{v[31]}}, v[31:0]} : v;
    endfunction

    function automatic logic [63:0] magnitude(input logic [63:0] v, input logic neg);
        magnitude = neg ? (~v + 64'd1) : v;
    endfunction

    // MUL keeps the low half of the product, the MULH family the high half
    function automatic logic [63:0] mul_select(input logic [4:0] op, input logic [127:0] p);
        mul_select = (op == ALU_MUL) ? p[63:0] : p[127:64];
    endfunction

endpackage

// File: rtl/ysyx_22040931_divcore.sv
// Restoring divider on unsigned magnitudes, one quotient bit per cycle.
// The final-step values are exported combinationally so the caller can
// register the signed result on the same edge as the last iteration.
module ysyx_22040931_divcore (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        start_i,
    input  logic        word_i,
    input  logic [63:0] dividend_i,
    input  logic [63:0] divisor_i,
    output logic        last_o,
    output logic [63:0] quo_next_o,
    output logic [63:0] rem_next_o
);

    logic [63:0] rem_q;
    logic [63:0] quo_q;
    logic [63:0] dvsr_q;
    logic [6:0]  cnt_q;
    logic        busy_q;
    logic [64:0] rem_sh_s;
    logic [64:0] diff_s;

    // Shift in the next dividend bit; bit 64 of the difference is the borrow
    assign rem_sh_s   = {rem_q, quo_q[63]};
    assign diff_s     = rem_sh_s - {1'b0, dvsr_q};
    assign quo_next_o = {quo_q[62:0], ~diff_s[64]};
    assign rem_next_o = diff_s[64] ? rem_sh_s[63:0] : diff_s[63:0];
    assign last_o     = busy_q & (cnt_q == 7'd1);

    // Magnitude registers and iteration counter
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= 64'd0;
            quo_q  <= 64'd0;
            dvsr_q <= 64'd0;
            cnt_q  <= 7'd0;
            busy_q <= 1'b0;
        end else if (flush_i) begin
            cnt_q  <= 7'd0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            rem_q  <= 64'd0;
            // Word dividends sit in the top half so 32 steps consume them
            quo_q  <= word_i ? {dividend_i[31:0], 32'd0} : dividend_i;
            dvsr_q <= divisor_i;
            cnt_q  <= word_i ? 7'd32 : 7'd64;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            rem_q  <= rem_next_o;
            quo_q  <= quo_next_o;
            cnt_q  <= cnt_q - 7'd1;
            busy_q <= (cnt_q != 7'd1);
        end else begin
            busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/ysyx_22040931_mdu.sv
// RV64M iterative multiply/divide unit with valid/ready handshake.
// Optional feature macro: YSYX_22040931_MDU_FAST_MUL_EN selects a
// single-cycle combinational multiplier; divides stay iterative.
module ysyx_22040931_mdu
    import ysyx_22040931_mdu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      aluop,
    input  logic [2:0]      exop,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    mdu_state_e   state_q, state_d;
    logic [6:0]   cnt_q, cnt_d;
    logic [4:0]   op_q, op_d;
    logic         word_q, word_d;
    logic         neg_q, neg_d;
    logic         rem_neg_q, rem_neg_d;
    logic [63:0]  mcand_q, mcand_d;
    logic [127:0] acc_q, acc_d;
    logic [63:0]  result_q, result_d;
    logic         out_valid_q, busy_q, in_ready_q;

    // Request decode
    logic         accept_s, word_s, s1_sgn_s, s2_sgn_s, sign1_s, sign2_s;
    logic         is_m_s, div_zero_s, div_ovf_s, div_start_s;
    logic [63:0]  ext1_s, ext2_s, mag1_s, mag2_s, special_raw_s, special_s;

    assign accept_s = in_valid & (state_q == ST_IDLE) & ~flush;
    assign word_s   = (exop == EXOP_SHORT) | is_word_op(aluop);
    assign s1_sgn_s = src1_signed(aluop);
    assign s2_sgn_s = src2_signed(aluop);
    assign ext1_s   = ext_operand(src1, word_s, s1_sgn_s);
    assign ext2_s   = ext_operand(src2, word_s, s2_sgn_s);
    assign sign1_s  = s1_sgn_s & ext1_s[63];
    assign sign2_s  = s2_sgn_s & ext2_s[63];
    assign mag1_s   = magnitude(ext1_s, sign1_s);
    assign mag2_s   = magnitude(ext2_s, sign2_s);
    assign is_m_s   = is_mul_op(aluop) | is_div_op(aluop);

    assign div_zero_s = is_div_op(aluop) & (ext2_s == 64'd0);
    assign div_ovf_s  = is_div_op(aluop) & s1_sgn_s
                      & (ext1_s == (word_s ? 64'hFFFF_FFFF_8000_0000
                                           : 64'h8000_0000_0000_0000))
                      & (ext2_s == 64'hFFFF_FFFF_FFFF_FFFF);

    // Results that need no iteration: non-M ops, divide by zero, signed overflow
    always_comb begin
        special_raw_s = 64'd0;
        if (!is_m_s) begin
            special_raw_s = 64'd0;
        end else if (div_zero_s) begin
            special_raw_s = is_rem_op(aluop) ? ext1_s : 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (div_ovf_s) begin
            special_raw_s = is_rem_op(aluop) ? 64'd0 : ext1_s;
        end else begin
            special_raw_s = 64'd0;
        end
    end
    assign special_s = word_fix(special_raw_s, word_s);

    // Shift-add step: add multiplicand when the current multiplier bit is set
    logic [64:0]  mul_sum_s;
    logic [127:0] mul_step_s, mul_prod_s, mul_signed_s;
    logic [63:0]  mul_res_s;

    assign mul_sum_s    = {1'b0, acc_q[127:64]} + (acc_q[0] ? {1'b0, mcand_q} : 65'd0);
    assign mul_step_s   = {mul_sum_s, acc_q[63:1]};
    // After 32 steps the word product still sits 32 bits high
    assign mul_prod_s   = word_q ? {32'd0, mul_step_s[127:32]} : mul_step_s;
    assign mul_signed_s = neg_q ? (~mul_prod_s + 128'd1) : mul_prod_s;
    assign mul_res_s    = word_fix(mul_select(op_q, mul_signed_s), word_q);

`ifdef YSYX_22040931_MDU_FAST_MUL_EN
    logic [127:0] fast_prod_s, fast_signed_s;
    logic [63:0]  fast_res_s;

    assign fast_prod_s   = {64'd0, mag1_s} * {64'd0, mag2_s};
    assign fast_signed_s = (sign1_s ^ sign2_s) ? (~fast_prod_s + 128'd1) : fast_prod_s;
    assign fast_res_s    = word_fix(mul_select(aluop, fast_signed_s), word_s);
`endif

    // Divider datapath and sign correction
    logic         div_last_s;
    logic [63:0]  div_quo_s, div_rem_s, div_q_signed_s, div_r_signed_s, div_res_s;

    ysyx_22040931_divcore u_divcore (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush),
        .start_i    (div_start_s),
        .word_i     (word_s),
        .dividend_i (mag1_s),
        .divisor_i  (mag2_s),
        .last_o     (div_last_s),
        .quo_next_o (div_quo_s),
        .rem_next_o (div_rem_s)
    );

    assign div_q_signed_s = magnitude(div_quo_s, neg_q);
    assign div_r_signed_s = magnitude(div_rem_s, rem_neg_q);
    assign div_res_s      = word_fix(is_rem_op(op_q) ? div_r_signed_s : div_q_signed_s, word_q);

    // Next-state and datapath update for the IDLE/CALC/DONE controller
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        word_d      = word_q;
        neg_d       = neg_q;
        rem_neg_d   = rem_neg_q;
        mcand_d     = mcand_q;
        acc_d       = acc_q;
        result_d    = result_q;
        div_start_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    op_d      = aluop;
                    word_d    = word_s;
                    neg_d     = sign1_s ^ sign2_s;
                    rem_neg_d = sign1_s;
                    if (!is_m_s || div_zero_s || div_ovf_s) begin
                        state_d  = ST_DONE;
                        result_d = special_s;
                    end
`ifdef YSYX_22040931_MDU_FAST_MUL_EN
                    else if (is_mul_op(aluop)) begin
                        state_d  = ST_DONE;
                        result_d = fast_res_s;
                    end
`endif
                    else if (is_mul_op(aluop)) begin
                        state_d = ST_CALC;
                        cnt_d   = word_s ? 7'd32 : 7'd64;
                        acc_d   = {64'd0, mag2_s};
                        mcand_d = mag1_s;
                    end else begin
                        state_d     = ST_CALC;
                        div_start_s = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (is_mul_op(op_q)) begin
                    acc_d = mul_step_s;
                    cnt_d = cnt_q - 7'd1;
                    if (cnt_q == 7'd1) begin
                        state_d  = ST_DONE;
                        result_d = mul_res_s;
                    end else begin
                        state_d = ST_CALC;
                    end
                end else if (div_last_s) begin
                    state_d  = ST_DONE;
                    result_d = div_res_s;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 7'd0;
            end
        endcase
        // Flush wins over everything and discards any pending result
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = 7'd0;
        end else begin
            cnt_d = cnt_d;
        end
    end

    // State, datapath and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 7'd0;
            op_q        <= 5'd0;
            word_q      <= 1'b0;
            neg_q       <= 1'b0;
            rem_neg_q   <= 1'b0;
            mcand_q     <= 64'd0;
            acc_q       <= 128'd0;
            result_q    <= 64'd0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            word_q      <= word_d;
            neg_q       <= neg_d;
            rem_neg_q   <= rem_neg_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            out_valid_q <= (state_d == ST_DONE);
            busy_q      <= (state_d != ST_IDLE);
            in_ready_q  <= (state_d == ST_IDLE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign result    = result_q;

endmodule

// File: tb/tb_ysyx_22040931_mdu.sv
// Directed self-checking bench for ysyx_22040931_mdu.
module tb_ysyx_22040931_mdu;
    import ysyx_22040931_mdu_pkg::*;

`ifdef YSYX_22040931_MDU_FAST_MUL_EN
    localparam int MUL_LAT  = 1;
    localparam int MULW_LAT = 1;
`else
    localparam int MUL_LAT  = 65;
    localparam int MULW_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        rst, in_valid, flush, out_ready;
    logic [4:0]  aluop;
    logic [2:0]  exop;
    logic [63:0] src1, src2;
    logic        in_ready, out_valid, busy;
    logic [63:0] result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  op;
        logic [2:0]  ex;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    ysyx_22040931_mdu dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluop     (aluop),
        .exop      (exop),
        .src1      (src1),
        .src2      (src2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Called at #1 after an edge (cycle 0); returns at #1 after the accept edge (cycle 1)
    task automatic issue(input logic [4:0] op, input logic [2:0] ex,
                         input logic [63:0] a, input logic [63:0] b);
        aluop = op; exop = ex; src1 = a; src2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Returns the cycle number where out_valid is first seen, or -1 on timeout
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic retire;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_table(input vec_t vs[$], input string tag);
        int lat;
        foreach (vs[i]) begin
            issue(vs[i].op, vs[i].ex, vs[i].a, vs[i].b);
            wait_valid(lat);
            checks++;
            if (lat !== vs[i].lat) begin
                errors++;
                $display("FAIL %s_lat[%0d]: got %0d expected %0d", tag, i, lat, vs[i].lat);
            end
            checks++;
            if (result !== vs[i].exp) begin
                errors++;
                $display("FAIL %s_result[%0d]: got %h expected %h", tag, i, result, vs[i].exp);
            end
            retire;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (result !== 64'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
    endtask

    task automatic test_mul;
        vec_t vs[$];
        int lat;
        // MUL 7 x -3, also checking the busy/in_ready view while it runs
        issue(ALU_MUL, EXOP_ARITH, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL mul_busy: got busy=%b in_ready=%b expected 1/0", busy, in_ready);
        end
        wait_valid(lat);
        checks++; if (lat !== MUL_LAT) begin errors++; $display("FAIL mul_lat: got %0d expected %0d", lat, MUL_LAT); end
        checks++; if (result !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            errors++; $display("FAIL mul_result: got %h expected ffffffffffffffeb", result);
        end
        retire;
        vs.push_back('{ALU_MULHU,  EXOP_ARITH, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, MUL_LAT});
        vs.push_back('{ALU_MULH,   EXOP_ARITH, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, MUL_LAT});
        vs.push_back('{ALU_MULHSU, EXOP_ARITH, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, MUL_LAT});
        vs.push_back('{ALU_MUL,    EXOP_SHORT, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, MULW_LAT});
        run_table(vs, "mulx");
    endtask

    task automatic test_div_special;
        vec_t vs[$];
        vs.push_back('{ALU_DIVW, EXOP_ARITH, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1});
        vs.push_back('{ALU_REMW, EXOP_ARITH, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0, 1});
        vs.push_back('{ALU_DIV,  EXOP_ARITH, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1});
        vs.push_back('{ALU_REMU, EXOP_ARITH, 64'd100, 64'd0, 64'd100, 1});
        vs.push_back('{ALU_DIV,  EXOP_ARITH, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1});
        vs.push_back('{ALU_ADD,  EXOP_ARITH, 64'd3, 64'd4, 64'd0, 1});
        run_table(vs, "divspecial");
    endtask

    task automatic test_div;
        vec_t vs[$];
        vs.push_back('{ALU_DIVU,  EXOP_ARITH, 64'd100, 64'd7, 64'd14, 65});
        vs.push_back('{ALU_REM,   EXOP_ARITH, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65});
        vs.push_back('{ALU_DIV,   EXOP_ARITH, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65});
        vs.push_back('{ALU_DIVW,  EXOP_ARITH, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33});
        vs.push_back('{ALU_DIVUW, EXOP_ARITH, 64'h1234_5678_FFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, 33});
        run_table(vs, "div");
    endtask

    task automatic test_backpressure;
        int lat;
        issue(ALU_DIV, EXOP_ARITH, 64'd1000, 64'd3);
        wait_valid(lat);
        checks++; if (lat !== 65) begin errors++; $display("FAIL bp_lat: got %0d expected 65", lat); end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (result !== 64'd333 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got result=%h in_ready=%b out_valid=%b expected 14d/0/1",
                         k, result, in_ready, out_valid);
            end
            @(posedge clk); #1;
        end
        retire;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        issue(ALU_REMU, EXOP_ARITH, 64'd100, 64'd0);
        // Consumer accepts while the next request is already waiting
        aluop = ALU_DIVU; exop = EXOP_ARITH; src1 = 64'd20; src2 = 64'd5;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_no_same_cycle: got busy=%b in_ready=%b out_valid=%b expected 0/1/0",
                               busy, in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(lat);
        checks++; if (lat !== 65) begin errors++; $display("FAIL b2b_lat: got %0d expected 65", lat); end
        checks++; if (result !== 64'd4) begin errors++; $display("FAIL b2b_result: got %h expected 4", result); end
        retire;
        // Flush in the same cycle as a request blocks the accept
        aluop = ALU_MUL; src1 = 64'd2; src2 = 64'd3; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_blocks_accept: got busy=%b in_ready=%b expected 0/1", busy, in_ready);
        end
    endtask

    // use_rst selects rst instead of flush as the abort source
    task automatic abort_scenario(input logic use_rst, input string tag);
        int lat;
        issue(ALU_DIV, EXOP_ARITH, 64'd100, 64'd7);
        repeat (9) begin @(posedge clk); #1; end
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; flush = 1'b0;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL %s_idle: got busy=%b in_ready=%b out_valid=%b expected 0/1/0",
                               tag, busy, in_ready, out_valid);
        end
        if (use_rst) begin
            checks++; if (result !== 64'd0) begin errors++; $display("FAIL %s_clear: got %h expected 0", tag, result); end
        end
        issue(ALU_MUL, EXOP_ARITH, 64'd6, 64'd7);
        wait_valid(lat);
        checks++; if (lat !== MUL_LAT) begin errors++; $display("FAIL %s_mul_lat: got %0d expected %0d", tag, lat, MUL_LAT); end
        checks++; if (result !== 64'd42) begin errors++; $display("FAIL %s_mul_result: got %h expected 2a", tag, result); end
        retire;
    endtask

    task automatic test_flush;
        abort_scenario(1'b0, "flush");
        // A pending DONE is killed by flush
        issue(ALU_DIV, EXOP_ARITH, 64'd5, 64'd0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_done: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_rst_abort;
        abort_scenario(1'b1, "rst");
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        aluop = 5'd0; exop = 3'd0; src1 = 64'd0; src2 = 64'd0;
        test_reset();
        test_mul();
        test_div_special();
        test_div();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_rst_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
